// File: rtl/cache_pkg.sv
// Shared definitions for the cache access controller: geometry constants,
// controller state encoding and the cache_set phase encoding.
package cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int INDEX_W  = 2;
  localparam int OFFSET_W = 3;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int DATA_W   = 64;
  localparam int NUM_SETS = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    EVAL,
    FILL_REQ,
    FILL_WAIT,
    UPDATE,
    RESP
  } ctrl_state_t;

  // cache_set.state encoding
  localparam logic SET_SEARCH = 1'b0;
  localparam logic SET_UPDATE = 1'b1;

endpackage

// File: rtl/cache_stats_counter.sv
// Saturating 32-bit event counter used for hit/miss statistics.
// Only compiled when CACHE_ACCESS_CTRL_STATS_EN is defined.
`ifdef CACHE_ACCESS_CTRL_STATS_EN
module cache_stats_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_reg;

  // Count one event per cycle, sticking at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != 32'hFFFF_FFFF)) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign count = count_reg;

endmodule
`endif

// File: rtl/cache_access_ctrl.sv
// Requester-side sequencer for the cache_set array. A lookup runs
// SEARCH -> EVAL, then either goes straight to an UPDATE cycle that only
// clears the set's hit latch (hit), or fetches the line from backing memory
// and pushes it into the selected set during UPDATE (miss). The result is
// returned as a one-cycle rsp_valid strobe.
// Optional feature: define CACHE_ACCESS_CTRL_STATS_EN to add saturating
// hit_count / miss_count outputs.
module cache_access_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W   = cache_pkg::ADDR_W,
  parameter int INDEX_W  = cache_pkg::INDEX_W,
  parameter int OFFSET_W = cache_pkg::OFFSET_W,
  parameter int TAG_W    = cache_pkg::TAG_W,
  parameter int DATA_W   = cache_pkg::DATA_W,
  localparam int NUM_SETS = 1 << INDEX_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  output logic                       rsp_valid,
  output logic                       rsp_hit,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [NUM_SETS-1:0]        set_enable,
  output logic                       set_state,
  output logic [TAG_W-1:0]           set_tag,
  output logic                       set_mem_write,
  output logic [DATA_W-1:0]          set_write_data,
  input  logic [NUM_SETS-1:0]        set_hit,
  input  logic [NUM_SETS*DATA_W-1:0] set_read_data,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [ADDR_W-1:0]          mem_req_addr,
  input  logic                       mem_rsp_valid,
  input  logic [DATA_W-1:0]          mem_rsp_data
`ifdef CACHE_ACCESS_CTRL_STATS_EN
  ,
  output logic [31:0]                hit_count,
  output logic [31:0]                miss_count
`endif
);

  ctrl_state_t         state_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   line_reg;
  logic                hit_reg;
  logic [INDEX_W-1:0]  index;
  logic [NUM_SETS-1:0] index_onehot;
  logic [NUM_SETS-1:0] req_onehot;
  logic [DATA_W-1:0]   set_data_arr [NUM_SETS];

  // Unpack the flat per-set read bus into one word per set
  for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set_data
    assign set_data_arr[gi] = set_read_data[gi*DATA_W +: DATA_W];
  end

  assign index        = addr_reg[OFFSET_W +: INDEX_W];
  assign index_onehot = NUM_SETS'(1) << index;
  // The SEARCH select is registered on the accept edge, so it is decoded
  // from the incoming address rather than from addr_reg.
  assign req_onehot   = NUM_SETS'(1) << req_addr[OFFSET_W +: INDEX_W];

  assign set_tag        = addr_reg[ADDR_W-1 -: TAG_W];
  assign mem_req_addr   = {addr_reg[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  // On a hit line_reg holds the read data, but mem_write stays low then
  assign set_write_data = line_reg;

  // Controller FSM; every output is registered on the transition into the
  // state in which it must be visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      line_reg      <= '0;
      hit_reg       <= 1'b0;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_data      <= '0;
      set_enable    <= '0;
      set_state     <= SET_UPDATE;
      set_mem_write <= 1'b0;
      mem_req_valid <= 1'b0;
    end else begin
      rsp_valid     <= 1'b0;
      set_enable    <= '0;
      set_state     <= SET_UPDATE;
      set_mem_write <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_reg   <= req_addr;
            req_ready  <= 1'b0;
            set_state  <= SET_SEARCH;
            set_enable <= req_onehot;
            state_reg  <= SEARCH;
          end else begin
            req_ready <= 1'b1;
          end
        end
        SEARCH: begin
          state_reg <= EVAL;
        end
        EVAL: begin
          hit_reg <= set_hit[index];
          if (set_hit[index]) begin
            line_reg   <= set_data_arr[index];
            set_enable <= index_onehot;
            state_reg  <= UPDATE;
          end else begin
            mem_req_valid <= 1'b1;
            state_reg     <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_reg     <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (mem_rsp_valid) begin
            line_reg      <= mem_rsp_data;
            set_enable    <= index_onehot;
            set_mem_write <= 1'b1;
            state_reg     <= UPDATE;
          end
        end
        UPDATE: begin
          rsp_valid <= 1'b1;
          rsp_hit   <= hit_reg;
          rsp_data  <= line_reg;
          state_reg <= RESP;
        end
        RESP: begin
          req_ready <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_ACCESS_CTRL_STATS_EN
  // Tally each outcome during its response strobe
  cache_stats_counter u_hit_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (rsp_valid & rsp_hit),
    .count (hit_count)
  );

  cache_stats_counter u_miss_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (rsp_valid & ~rsp_hit),
    .count (miss_count)
  );
`endif

endmodule

// File: tb/tb_cache_access_ctrl.sv
// Testbench for cache_access_ctrl: directed table vectors, a mid-fill reset
// sequence and randomized lookups against a behavioural expectation model.
module tb_cache_access_ctrl;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          rsp_valid;
  logic          rsp_hit;
  logic [63:0]   rsp_data;
  logic [3:0]    set_enable;
  logic          set_state;
  logic [26:0]   set_tag;
  logic          set_mem_write;
  logic [63:0]   set_write_data;
  logic [3:0]    set_hit;
  logic [255:0]  set_read_data;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_req_addr;
  logic          mem_rsp_valid;
  logic [63:0]   mem_rsp_data;
`ifdef CACHE_ACCESS_CTRL_STATS_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  cache_access_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_hit        (rsp_hit),
    .rsp_data       (rsp_data),
    .set_enable     (set_enable),
    .set_state      (set_state),
    .set_tag        (set_tag),
    .set_mem_write  (set_mem_write),
    .set_write_data (set_write_data),
    .set_hit        (set_hit),
    .set_read_data  (set_read_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data)
`ifdef CACHE_ACCESS_CTRL_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] addr;
    logic        hit;
    logic [63:0] sdata;
    logic [63:0] mdata;
    int          d;        // cycles mem_req_ready held low
    int          r;        // FILL_WAIT cycles before the fill arrives
    logic        hold;     // keep req_valid high after acceptance
    logic        stray;    // inject ignored mem_rsp_valid pulses
    logic [3:0]  exp_en;
    logic [26:0] exp_tag;
    logic [31:0] exp_line;
    int          exp_lat;  // clock edges from accept edge to rsp_valid
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic hit, input logic [63:0] sdata,
                              input logic [63:0] mdata, input int d, input int r, input logic hold,
                              input logic stray, input logic [3:0] en, input logic [26:0] tag,
                              input logic [31:0] line, input int lat);
    vec_t v;
    v.addr = addr; v.hit = hit; v.sdata = sdata; v.mdata = mdata; v.d = d; v.r = r;
    v.hold = hold; v.stray = stray; v.exp_en = en; v.exp_tag = tag; v.exp_line = line;
    v.exp_lat = lat;
    return v;
  endfunction

  // Expectations from the address/latency rules with plain arithmetic
  function automatic vec_t model(input vec_t v);
    vec_t m;
    m = v;
    m.exp_en   = 4'(1 << ((v.addr / 32'd8) % 32'd4));
    m.exp_tag  = 27'(v.addr / 32'd32);
    m.exp_line = v.addr - (v.addr % 32'd8);
    m.exp_lat  = v.hit ? 3 : 5 + v.d + v.r;
    return m;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int   waited;
    int   en_cnt, en_bad, mw_cnt, mrv_cnt, maddr_bad, rsp_cnt, rsp_at, rdy_busy;
    int   wcnt, rcnt;
    bit   hs, sent;
    logic [4:0]  srch;
    logic [26:0] srch_tag;
    logic [5:0]  upd;
    logic [63:0] upd_wd;
    logic        rsp_h;
    logic [63:0] rsp_d;
    logic [1:0]  idx;
    en_cnt = 0; en_bad = 0; mw_cnt = 0; mrv_cnt = 0; maddr_bad = 0; rsp_cnt = 0;
    rsp_at = -1; rdy_busy = 0; wcnt = 0; rcnt = 0; hs = 0; sent = 0;
    srch = '0; srch_tag = '0; upd = '0; upd_wd = '0; rsp_h = 1'b0; rsp_d = '0;
    idx = 2'((v.addr / 32'd8) % 32'd4);

    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = v.addr;
    for (int i = 0; i < 4; i++) set_read_data[i*64 +: 64] = {$urandom, $urandom};
    set_read_data[int'(idx)*64 +: 64] = v.sdata;
    set_hit = 4'($urandom_range(0, 15));
    set_hit[idx] = v.hit;
    mem_req_ready = 1'b0;
    mem_rsp_valid = v.stray;
    mem_rsp_data  = ~v.mdata;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", 64'(req_ready), 64'd1);

    if (req_ready) begin
      for (int k = 0; k <= v.exp_lat; k++) begin
        @(negedge clk);
        if (k == 0 && !v.hold) req_valid = 1'b0;
        if (set_enable != 4'd0) begin
          en_cnt++;
          if (!((k == 0 || k == v.exp_lat - 1) && set_enable == v.exp_en)) en_bad++;
        end
        if (k == 0) begin
          srch     = {set_state, set_enable};
          srch_tag = set_tag;
        end
        if (k == v.exp_lat - 1) begin
          upd    = {set_state, set_enable, set_mem_write};
          upd_wd = set_write_data;
        end
        if (set_mem_write) mw_cnt++;
        if (mem_req_valid) begin
          mrv_cnt++;
          if (mem_req_addr !== v.exp_line) maddr_bad++;
        end
        if (rsp_valid) begin
          rsp_cnt++;
          rsp_at = k;
          rsp_h  = rsp_hit;
          rsp_d  = rsp_data;
        end
        if (req_ready) rdy_busy++;
        // Memory responder for the next edge
        mem_req_ready = 1'b0;
        mem_rsp_valid = v.stray & 1'($urandom_range(0, 1));
        mem_rsp_data  = ~v.mdata;
        if (mem_req_valid && !hs) begin
          if (wcnt == v.d) begin
            mem_req_ready = 1'b1;
            hs = 1;
          end else begin
            wcnt++;
          end
        end else if (hs && !sent) begin
          mem_rsp_valid = 1'b0;
          if (rcnt == v.r) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = v.mdata;
            sent = 1;
          end else begin
            rcnt++;
          end
        end
      end
      mem_rsp_valid = 1'b0;

      check("search_state_en", 64'(srch), 64'({1'b0, v.exp_en}));
      check("search_tag", 64'(srch_tag), 64'(v.exp_tag));
      check("enable_cycles", 64'(en_cnt), 64'd2);
      check("enable_illegal", 64'(en_bad), 64'd0);
      check("update_ctrl", 64'(upd), 64'({1'b1, v.exp_en, ~v.hit}));
      if (!v.hit) check("update_wdata", upd_wd, v.mdata);
      check("mem_write_count", 64'(mw_cnt), 64'(v.hit ? 0 : 1));
      check("mem_req_cycles", 64'(mrv_cnt), 64'(v.hit ? 0 : v.d + 1));
      check("mem_req_addr", 64'(maddr_bad), 64'd0);
      check("rsp_count", 64'(rsp_cnt), 64'd1);
      check("rsp_latency", 64'(rsp_at), 64'(v.exp_lat));
      check("rsp_hit", 64'(rsp_h), 64'(v.hit));
      check("rsp_data", rsp_d, v.hit ? v.sdata : v.mdata);
      check("ready_while_busy", 64'(rdy_busy), 64'd0);
    end else begin
      req_valid = 1'b0;
    end
    $display("txn %0d addr=%08h hit=%0d d=%0d r=%0d lat=%0d rsp_at=%0d data=%016h",
             id, v.addr, v.hit, v.d, v.r, v.exp_lat, rsp_at, rsp_d);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 64'({req_ready, rsp_valid, rsp_hit, set_state, set_mem_write, mem_req_valid,
                     set_enable}), 64'({6'b000100, 4'b0000}));
    check({name, "_data"}, rsp_data, 64'd0);
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    int id;
    int mw_cnt, rsp_cnt, en_cnt;
    logic seen_mrv, ready_after;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; set_hit = '0; set_read_data = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Directed vectors with hand-derived expectations
    vecs.push_back(mk(32'h0000_1000, 0, 64'h0, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0,
                      4'b0001, 27'h80, 32'h0000_1000, 5));
    vecs.push_back(mk(32'h0000_1004, 1, 64'hDEAD_BEEF_0123_4567, 64'h0, 0, 0, 0, 0,
                      4'b0001, 27'h80, 32'h0000_1000, 3));
    vecs.push_back(mk(32'h0000_001C, 0, 64'h0, 64'h1111_2222_3333_4444, 5, 1, 0, 0,
                      4'b1000, 27'h0, 32'h0000_0018, 11));
    vecs.push_back(mk(32'hFFFF_FFFF, 1, 64'hCAFE_F00D_8765_4321, 64'h0, 0, 0, 0, 1,
                      4'b1000, 27'h7FF_FFFF, 32'hFFFF_FFF8, 3));
    vecs.push_back(mk(32'hFFFF_FFF7, 0, 64'h0, 64'h0F0F_0F0F_F0F0_F0F0, 2, 0, 0, 1,
                      4'b0100, 27'h7FF_FFFF, 32'hFFFF_FFF0, 7));
    vecs.push_back(mk(32'h0000_0020, 1, 64'hA5A5_A5A5_5A5A_5A5A, 64'h0, 0, 0, 1, 0,
                      4'b0001, 27'h1, 32'h0000_0020, 3));
    vecs.push_back(mk(32'h0000_0028, 0, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 2, 1, 0,
                      4'b0010, 27'h1, 32'h0000_0028, 8));
    vecs.push_back(mk(32'h0000_0030, 1, 64'h7777_8888_9999_AAAA, 64'h0, 0, 0, 0, 0,
                      4'b0100, 27'h1, 32'h0000_0030, 3));
    id = 0;
    foreach (vecs[i]) begin
      run_vec(vecs[i], id);
      id++;
    end

    // Reset during FILL_WAIT, followed by a late fill response
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_0040; set_hit = 4'b0000;
    seen_mrv = 1'b0;
    check("rst_seq_accept", 64'(req_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      if (k == 2) seen_mrv = mem_req_valid;
      mem_req_ready = (k == 2);
    end
    check("rst_seq_reached_fill", 64'(seen_mrv), 64'd1);
    rst = 1'b1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_seq_outputs");
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 64'hBAD0_BAD0_BAD0_BAD0;
    mw_cnt = 0; rsp_cnt = 0; en_cnt = 0; ready_after = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (k == 0) ready_after = req_ready;
      if (set_mem_write) mw_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (set_enable != 4'd0) en_cnt++;
    end
    check("rst_seq_ready", 64'(ready_after), 64'd1);
    check("rst_seq_no_write", 64'(mw_cnt), 64'd0);
    check("rst_seq_no_rsp", 64'(rsp_cnt), 64'd0);
    check("rst_seq_no_enable", 64'(en_cnt), 64'd0);
    $display("txn %0d reset during FILL_WAIT with late fill", id);
    id++;

    // Randomized lookups
    for (int n = 0; n < 30; n++) begin
      v.addr  = $urandom;
      v.hit   = 1'($urandom_range(0, 1));
      v.sdata = {$urandom, $urandom};
      v.mdata = {$urandom, $urandom};
      v.d     = int'($urandom_range(0, 3));
      v.r     = int'($urandom_range(0, 3));
      v.hold  = 1'b0;
      v.stray = 1'($urandom_range(0, 1));
      run_vec(model(v), id);
      id++;
    end

    // Quiet interval: nothing may be issued without a request
    mw_cnt = 0; rsp_cnt = 0; en_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (set_mem_write) mw_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (set_enable != 4'd0 || mem_req_valid) en_cnt++;
    end
    check("idle_quiet", 64'({mw_cnt[7:0], rsp_cnt[7:0], en_cnt[7:0]}), 64'd0);

`ifdef CACHE_ACCESS_CTRL_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("stats_reset", 64'({hit_count, miss_count}), 64'd0);
    run_vec(model(mk(32'h100, 1, 64'h11, 64'h0, 0, 0, 0, 0, 4'd0, 27'd0, 32'd0, 0)), id++);
    run_vec(model(mk(32'h208, 1, 64'h22, 64'h0, 0, 0, 0, 0, 4'd0, 27'd0, 32'd0, 0)), id++);
    run_vec(model(mk(32'h310, 0, 64'h0, 64'h33, 1, 1, 0, 0, 4'd0, 27'd0, 32'd0, 0)), id++);
    @(negedge clk);
    check("stats_hit_count", 64'(hit_count), 64'd2);
    check("stats_miss_count", 64'(miss_count), 64'd1);
    force dut.u_hit_counter.count_reg = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.u_hit_counter.count_reg;
    run_vec(model(mk(32'h418, 1, 64'h44, 64'h0, 0, 0, 0, 0, 4'd0, 27'd0, 32'd0, 0)), id++);
    @(negedge clk);
    check("stats_hit_saturated", 64'(hit_count), 64'hFFFF_FFFF);
    check("stats_miss_unchanged", 64'(miss_count), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
